madd_err_acc: RTL and testbench
===============================

MADD_ERR_ACC -- requirements
Module: madd_err_acc

Interface
REQ-001 SHALL have parameter W, default 3, operand width of the adder under evaluation.
REQ-002 SHALL have parameter CNT_W, default 16, width of the vector and error counters.
REQ-003 SHALL have parameter SUM_W, default 24, width of the absolute-error accumulator.
REQ-004 SHALL have port clk  in  1  sole clock, rising edge.
REQ-005 SHALL have port rst  in  1  synchronous reset, active-high.
REQ-006 SHALL have port start  in  1  one-cycle pulse that opens a session.
REQ-007 SHALL have port in_valid  in  1  vector present.
REQ-008 SHALL have port in_ready  out  1  vector accepted when in_valid and in_ready are both high.
REQ-009 SHALL have port in_a  in  W  operand A.
REQ-010 SHALL have port in_b  in  W  operand B.
REQ-011 SHALL have port in_approx  in  W+1  approximate adder output for (in_a, in_b).
REQ-012 SHALL have port in_last  in  1  marks the final vector of the session.
REQ-013 SHALL have port busy  out  1  high in RUN.
REQ-014 SHALL have port done  out  1  high in DONE.
REQ-015 SHALL have port vec_count  out  CNT_W  number of vectors accumulated.
REQ-016 SHALL have port err_count  out  CNT_W  number of vectors with a nonzero error.
REQ-017 SHALL have port sum_abs_err  out  SUM_W  sum of absolute errors.
REQ-018 SHALL have port max_abs_err  out  W+1  largest absolute error (present only with MADD_ERR_MAX_EN).

Function
REQ-019 SHALL implement the FSM states IDLE, RUN and DONE.
REQ-020 SHALL, in IDLE or DONE, on start: clear all statistics and the pipeline, then enter RUN the next cycle.
REQ-021 SHALL ignore start in RUN.
REQ-022 SHALL drive in_ready = (state==RUN) && !last_seen; last_seen is set when a vector with in_last=1 is accepted.
REQ-023 SHALL compute the exact sum as in_a+in_b zero-extended to W+1 bits, and abs_err = |exact - in_approx| in W+1 bits, with no overflow possible.
REQ-024 SHALL register exact, abs_err and the accept flag in stage 1, and update the statistics in stage 2; an accepted vector SHALL be reflected in the outputs exactly 2 cycles after its accept edge.
REQ-025 SHALL accept one vector per cycle with no bubbles while in_valid is held high.
REQ-026 SHALL increment vec_count on every accumulated vector, and err_count only when abs_err != 0.
REQ-027 SHALL saturate vec_count and err_count at 2^CNT_W-1, and sum_abs_err at 2^SUM_W-1, with no wrap-around.
REQ-028 SHALL move from RUN to DONE in the cycle after the last vector's stage-2 update; done and the statistics then hold until start or rst.
REQ-029 SHALL keep in_valid with in_ready low as no accept, leaving the state unchanged.

Reset
REQ-030 SHALL, on rst high at a clock edge, force state=IDLE, in_ready=0, busy=0, done=0, and zero all counters, max_abs_err, last_seen and the pipeline registers.
REQ-031 SHALL give rst priority over start and over an accept in the same cycle; an in-flight vector SHALL be discarded.

Configuration
REQ-032 SHALL, with MADD_ERR_MAX_EN defined, include max_abs_err: updated in stage 2 to max(current, abs_err) and cleared on start and rst.
REQ-033 SHALL, without MADD_ERR_MAX_EN, omit the max_abs_err port and register; all other behaviour and latency are unchanged.

Structure
REQ-034 SHALL place the FSM state typedef (IDLE/RUN/DONE) and the default width constants in package madd_err_pkg.
REQ-035 SHALL use one sub-module, madd_err_abs, which is combinational, parametrised by W, and produces exact and abs_err.

Verification
REQ-036 SHALL cover: W=3, start, one vector a=3 b=2 approx=5 last=1 -> 2 cycles after accept vec_count=1, err_count=0, sum_abs_err=0; done the following cycle.
REQ-037 SHALL cover: vectors (3,2,approx 4), (7,7,approx 0) and (1,1,approx 2, last) back-to-back -> vec_count=3, err_count=2, sum_abs_err=15, max_abs_err=14 (with the macro defined).
REQ-038 SHALL cover: CNT_W=4, 20 accepted vectors each with error 1 -> vec_count=15, err_count=15, sum_abs_err=20.
REQ-039 SHALL cover: start pulsed mid-RUN -> counters unchanged and state stays RUN; start in DONE -> all statistics read 0 on the next cycle.
REQ-040 SHALL cover: rst asserted one cycle after an accept -> every output reads 0, state IDLE, and the in-flight vector is never counted.
REQ-041 SHALL cover: in_valid held high after the last vector is accepted -> in_ready=0 and no further counting.

Source files
------------

// File: rtl/madd_err_pkg.sv
// Shared types and default widths for the approximate-adder error accumulator.
package madd_err_pkg;

  localparam int unsigned DefaultW    = 3;
  localparam int unsigned DefaultCntW = 16;
  localparam int unsigned DefaultSumW = 24;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

endpackage

// File: rtl/madd_err_acc_if.sv
// Vector stream into the error accumulator: valid/ready handshake plus operands,
// the approximate result under test and an end-of-session marker.
interface madd_err_acc_if
  import madd_err_pkg::*;
#(
  parameter int unsigned W = DefaultW
) ();

  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [W:0]   in_approx;
  logic         in_last;

  modport master (
    output in_valid,
    output in_a,
    output in_b,
    output in_approx,
    output in_last,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_a,
    input  in_b,
    input  in_approx,
    input  in_last,
    output in_ready
  );

endinterface

// File: rtl/madd_err_abs.sv
// Exact reference sum of two W-bit operands and its absolute distance from the
// approximate adder's result. Purely combinational.
module madd_err_abs
  import madd_err_pkg::*;
#(
  parameter int unsigned W = DefaultW
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [W:0]   approx_i,
  output logic [W:0]   exact_o,
  output logic [W:0]   abs_err_o
);

  // W+1 bits hold any W-bit sum, so neither the sum nor the difference can overflow.
  always_comb begin
    exact_o   = (W+1)'(a_i) + (W+1)'(b_i);
    abs_err_o = (exact_o >= approx_i) ? (exact_o - approx_i) : (approx_i - exact_o);
  end

endmodule

// File: rtl/madd_err_acc.sv
// Error-statistics accumulator for an approximate adder. A session opens on
// start, accepts vectors until one flagged last, and reports vector count,
// nonzero-error count and saturating sum of absolute errors.
// Define MADD_ERR_MAX_EN to add the max_abs_err output and its register.
module madd_err_acc
  import madd_err_pkg::*;
#(
  parameter int unsigned W     = DefaultW,
  parameter int unsigned CNT_W = DefaultCntW,
  parameter int unsigned SUM_W = DefaultSumW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  madd_err_acc_if.slave    in_if,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] vec_count,
  output logic [CNT_W-1:0] err_count,
  output logic [SUM_W-1:0] sum_abs_err
`ifdef MADD_ERR_MAX_EN
  ,
  output logic [W:0]       max_abs_err
`endif
);

  localparam logic [W:0] MaxExact = (W+1)'(2 * ((2 ** W) - 1));

  state_e           state_q, state_d;
  logic             last_seen_q, last_seen_d;
  logic             s1_valid_q, s1_valid_d;
  logic             s1_last_q, s1_last_d;
  logic [W:0]       s1_exact_q, s1_exact_d;
  logic [W:0]       s1_abs_q, s1_abs_d;
  logic             s2_last_q, s2_last_d;
  logic [CNT_W-1:0] vec_q, vec_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic [SUM_W:0]   sum_ext;
`ifdef MADD_ERR_MAX_EN
  logic [W:0]       max_q, max_d;
`endif

  logic [W:0] exact;
  logic [W:0] abs_err;
  logic       in_ready;
  logic       accept;

  madd_err_abs #(
    .W(W)
  ) u_abs (
    .a_i      (in_if.in_a),
    .b_i      (in_if.in_b),
    .approx_i (in_if.in_approx),
    .exact_o  (exact),
    .abs_err_o(abs_err)
  );

  // Handshake: a session stops taking vectors once its last one is in.
  always_comb begin
    in_ready = (state_q == StRun) && !last_seen_q;
    accept   = in_if.in_valid && in_ready;
  end

  assign in_if.in_ready = in_ready;

  // Next state: stage 1 captures the error, stage 2 folds it into the statistics.
  always_comb begin
    state_d     = state_q;
    last_seen_d = last_seen_q;
    s1_valid_d  = accept;
    s1_last_d   = accept && in_if.in_last;
    s1_exact_d  = exact;
    s1_abs_d    = abs_err;
    s2_last_d   = s1_valid_q && s1_last_q;
    vec_d       = vec_q;
    err_d       = err_q;
    sum_d       = sum_q;
    sum_ext     = {1'b0, sum_q} + (SUM_W+1)'(s1_abs_q);
`ifdef MADD_ERR_MAX_EN
    max_d       = max_q;
`endif

    if (s1_valid_q) begin
      if (vec_q != '1) vec_d = vec_q + CNT_W'(1);
      if ((s1_abs_q != '0) && (err_q != '1)) err_d = err_q + CNT_W'(1);
      sum_d = sum_ext[SUM_W] ? '1 : sum_ext[SUM_W-1:0];
`ifdef MADD_ERR_MAX_EN
      if (s1_abs_q > max_q) max_d = s1_abs_q;
`endif
    end

    if (accept && in_if.in_last) last_seen_d = 1'b1;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          state_d     = StRun;
          last_seen_d = 1'b0;
          s1_valid_d  = 1'b0;
          s1_last_d   = 1'b0;
          s1_exact_d  = '0;
          s1_abs_d    = '0;
          s2_last_d   = 1'b0;
          vec_d       = '0;
          err_d       = '0;
          sum_d       = '0;
`ifdef MADD_ERR_MAX_EN
          max_d       = '0;
`endif
        end
      end
      StRun: begin
        // s2_last_q marks the cycle after the final statistics update.
        if (s2_last_q) state_d = StDone;
      end
      default: state_d = StIdle;
    endcase
  end

  // State and pipeline registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      last_seen_q <= 1'b0;
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_exact_q  <= '0;
      s1_abs_q    <= '0;
      s2_last_q   <= 1'b0;
      vec_q       <= '0;
      err_q       <= '0;
      sum_q       <= '0;
`ifdef MADD_ERR_MAX_EN
      max_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      last_seen_q <= last_seen_d;
      s1_valid_q  <= s1_valid_d;
      s1_last_q   <= s1_last_d;
      s1_exact_q  <= s1_exact_d;
      s1_abs_q    <= s1_abs_d;
      s2_last_q   <= s2_last_d;
      vec_q       <= vec_d;
      err_q       <= err_d;
      sum_q       <= sum_d;
`ifdef MADD_ERR_MAX_EN
      max_q       <= max_d;
`endif
    end
  end

  // The registered exact sum of two W-bit operands can never exceed 2*(2^W-1).
  assert property (@(posedge clk) disable iff (rst) s1_valid_q |-> (s1_exact_q <= MaxExact));

  assign busy        = (state_q == StRun);
  assign done        = (state_q == StDone);
  assign vec_count   = vec_q;
  assign err_count   = err_q;
  assign sum_abs_err = sum_q;
`ifdef MADD_ERR_MAX_EN
  assign max_abs_err = max_q;
`endif

endmodule

// File: tb/tb_madd_err_acc.sv
// Randomised scoreboard bench for madd_err_acc (small counters to reach saturation).
module tb_madd_err_acc;

  localparam int unsigned W      = 3;
  localparam int unsigned CNT_W  = 4;
  localparam int unsigned SUM_W  = 8;
  localparam int          CntMax = (1 << CNT_W) - 1;
  localparam int          SumMax = (1 << SUM_W) - 1;

  localparam int TReset  = 0;
  localparam int TStart  = 1;
  localparam int TAccept = 2;
  localparam int TDone   = 3;
  localparam int TSnap   = 4;

  typedef struct {
    int at;
    int vec;
    int err;
    int sum;
    int mx;
    bit busy;
    bit done;
    int tag;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] vec_count;
  logic [CNT_W-1:0] err_count;
  logic [SUM_W-1:0] sum_abs_err;
`ifdef MADD_ERR_MAX_EN
  logic [W:0]       max_abs_err;
`endif

  madd_err_acc_if #(.W(W)) bus ();

  madd_err_acc #(
    .W    (W),
    .CNT_W(CNT_W),
    .SUM_W(SUM_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .in_if      (bus),
    .busy       (busy),
    .done       (done),
    .vec_count  (vec_count),
    .err_count  (err_count),
    .sum_abs_err(sum_abs_err)
`ifdef MADD_ERR_MAX_EN
    ,
    .max_abs_err(max_abs_err)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  // Reference model: unsaturated session totals; clamping happens when an expectation is formed.
  int m_state     = 0;  // 0 idle, 1 run, 2 done
  bit m_last_seen = 1'b0;
  int m_done_at   = 0;
  int m_vec       = 0;
  int m_err       = 0;
  int m_sum       = 0;
  int m_max       = 0;

  function automatic string tag_name(input int t);
    case (t)
      TReset:  return "reset";
      TStart:  return "start";
      TAccept: return "accept";
      TDone:   return "done";
      default: return "snap";
    endcase
  endfunction

  function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endfunction

  function automatic int clamp(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  function automatic void push_exp(input int at, input int tag);
    exp_t e;
    e.at  = at;
    e.vec = clamp(m_vec, CntMax);
    e.err = clamp(m_err, CntMax);
    e.sum = clamp(m_sum, SumMax);
    e.mx  = m_max;
    e.tag = tag;
    case (tag)
      TReset:          begin e.busy = 1'b0; e.done = 1'b0; end
      TStart, TAccept: begin e.busy = 1'b1; e.done = 1'b0; end
      TDone:           begin e.busy = 1'b0; e.done = 1'b1; end
      default:         begin e.busy = (m_state == 1); e.done = (m_state == 2); end
    endcase
    sb.push_back(e);
  endfunction

  // Monitor: every expectation due at this cycle is compared against the outputs.
  initial begin
    exp_t  it;
    string nm;
    forever begin
      @(negedge clk);
      while (sb.size() > 0 && sb[0].at <= cyc) begin
        it = sb.pop_front();
        nm = tag_name(it.tag);
        if (it.at != cyc) begin
          n_checks++;
          n_fail++;
          $display("FAIL %s order: expectation for cycle %0d seen at %0d", nm, it.at, cyc);
        end else begin
          check({nm, ".vec_count"}, 32'(vec_count), it.vec);
          check({nm, ".err_count"}, 32'(err_count), it.err);
          check({nm, ".sum_abs_err"}, 32'(sum_abs_err), it.sum);
          check({nm, ".busy"}, {31'b0, busy}, {31'b0, it.busy});
          check({nm, ".done"}, {31'b0, done}, {31'b0, it.done});
`ifdef MADD_ERR_MAX_EN
          check({nm, ".max_abs_err"}, 32'(max_abs_err), it.mx);
`endif
        end
      end
    end
  end

  // One cycle of stimulus; the model decides acceptance and queues the expected outcome.
  task automatic drive(input bit v, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W:0] ap, input bit last, input bit st, input bit r,
                       output bit acc);
    bit   exp_ready;
    int   ex;
    int   ab;
    exp_t keep[$];
    @(negedge clk);
    if (m_state == 1 && m_done_at != 0 && cyc >= m_done_at) m_state = 2;
    exp_ready = (m_state == 1) && !m_last_seen;
    check("in_ready", {31'b0, bus.in_ready}, {31'b0, exp_ready});
    rst           = r;
    start         = st;
    bus.in_valid  = v;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_approx = ap;
    bus.in_last   = last;
    acc           = 1'b0;
    if (r) begin
      foreach (sb[i]) if (sb[i].at <= cyc) keep.push_back(sb[i]);
      sb          = keep;
      m_state     = 0;
      m_last_seen = 1'b0;
      m_done_at   = 0;
      m_vec = 0; m_err = 0; m_sum = 0; m_max = 0;
      push_exp(cyc + 1, TReset);
    end else if (st && m_state != 1) begin
      m_state     = 1;
      m_last_seen = 1'b0;
      m_done_at   = 0;
      m_vec = 0; m_err = 0; m_sum = 0; m_max = 0;
      push_exp(cyc + 1, TStart);
    end else if (v && exp_ready) begin
      acc = 1'b1;
      ex  = int'(a) + int'(b);
      ab  = (ex > int'(ap)) ? ex - int'(ap) : int'(ap) - ex;
      m_vec++;
      if (ab != 0) m_err++;
      m_sum += ab;
      if (ab > m_max) m_max = ab;
      push_exp(cyc + 2, TAccept);
      if (last) begin
        m_last_seen = 1'b1;
        m_done_at   = cyc + 3;
        push_exp(cyc + 3, TDone);
      end
    end
  endtask

  task automatic idle();
    bit acc;
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b0, acc);
  endtask

  task automatic start_pulse();
    bit acc;
    drive(1'b0, '0, '0, '0, 1'b0, 1'b1, 1'b0, acc);
  endtask

  task automatic vec(input int a, input int b, input int ap, input bit last);
    bit acc;
    drive(1'b1, W'(a), W'(b), (W+1)'(ap), last, 1'b0, 1'b0, acc);
  endtask

  task automatic rand_session(input int nvec, input int pv);
    int             sent;
    int             guard;
    bit             acc;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [W:0]     ap;
    sent  = 0;
    guard = 0;
    start_pulse();
    while (sent < nvec && guard < 4 * nvec + 20) begin
      a  = W'($urandom);
      b  = W'($urandom);
      ap = ($urandom_range(2) == 0) ? (W+1)'(a) + (W+1)'(b) : (W+1)'($urandom);
      drive($urandom_range(99) < pv, a, b, ap, sent == nvec - 1, 1'b0, 1'b0, acc);
      if (acc) sent++;
      guard++;
    end
    repeat (4) idle();
  endtask

  initial begin
    bit acc;
    rst           = 1'b1;
    start         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_approx = '0;
    bus.in_last   = 1'b0;

    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
    idle();

    // Single exact vector.
    start_pulse();
    vec(3, 2, 5, 1'b1);
    repeat (4) idle();

    // Three back-to-back vectors, then in_valid held after the last one.
    start_pulse();
    vec(3, 2, 4, 1'b0);
    vec(7, 7, 0, 1'b0);
    vec(1, 1, 2, 1'b1);
    repeat (3) vec(int'($urandom_range(7)), int'($urandom_range(7)), 0, 1'b0);
    repeat (3) idle();

    // Start during RUN is ignored, even alongside an accepted vector.
    start_pulse();
    vec(2, 2, 7, 1'b0);
    drive(1'b1, W'(5), W'(1), (W+1)'(6), 1'b0, 1'b1, 1'b0, acc);
    repeat (2) idle();
    start_pulse();
    push_exp(cyc + 1, TSnap);
    vec(6, 5, 1, 1'b1);
    repeat (4) idle();

    // Twenty vectors each off by one: counters saturate, the sum does not.
    start_pulse();
    for (int i = 0; i < 20; i++) begin
      int a = int'($urandom_range(7));
      int b = int'($urandom_range(7));
      vec(a, b, a + b + 1, i == 19);
    end
    repeat (4) idle();

    // Twenty maximal errors drive the sum into saturation.
    start_pulse();
    for (int i = 0; i < 20; i++) vec(0, 0, 15, i == 19);
    repeat (4) idle();

    // Reset one cycle after an accept discards the in-flight vector.
    start_pulse();
    vec(7, 7, 1, 1'b0);
    drive(1'b0, '0, '0, '0, 1'b0, 1'b0, 1'b1, acc);
    idle();
    push_exp(cyc + 1, TSnap);
    repeat (3) idle();

    for (int s = 0; s < 4; s++) rand_session(int'($urandom_range(5, 30)), 70);

    repeat (4) idle();
    if (sb.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
